// File: rtl/ctrl_vec_mem_write_if.sv
// Bundle of the upstream stream, control and memory-write signals of
// ctrl_vec_mem_write.
//
// Handshake: an upstream beat transfers on a rising clk edge only when
// s_valid and s_ready are both high. s_ready never looks at s_valid.
// mem_wr_en marks the cycles in which a beat is really written to memory.
interface ctrl_vec_mem_write_if #(
  parameter int MEM_ADDR_WIDTH = 3
);
  logic                      s_valid;
  logic                      en_ext_ctrl;
  logic                      next_write;
  logic                      ready_y;
  logic                      clear;
  logic                      s_ready;
  logic                      mem_wr_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr;
  logic [MEM_ADDR_WIDTH:0]   x_count;
  logic                      mem_full;
  logic                      wrap_pulse;
  logic [1:0]                state_dbg;

  // Producer/controller side (the testbench or parent logic)
  modport master (
    output s_valid, en_ext_ctrl, next_write, ready_y, clear,
    input  s_ready, mem_wr_en, mem_wr_addr, x_count, mem_full, wrap_pulse,
    input  state_dbg
  );

  // Write controller side
  modport slave (
    input  s_valid, en_ext_ctrl, next_write, ready_y, clear,
    output s_ready, mem_wr_en, mem_wr_addr, x_count, mem_full, wrap_pulse,
    output state_dbg
  );
endinterface

// File: rtl/ctrl_vec_mem_write.sv
// Write controller for a small vector memory. It first fills the memory
// (LOAD), then holds it (FULL), and optionally overwrites it in a circular
// fashion while a consumer allows it (STREAM).
module ctrl_vec_mem_write #(
  parameter int MEM_SIZE       = 8,
  parameter int MEM_ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_vec_mem_write_if.slave   bus
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR  = MEM_ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE   = MEM_ADDR_WIDTH'(1);
  localparam logic [MEM_ADDR_WIDTH:0]   CNT_FULL   = (MEM_ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [MEM_ADDR_WIDTH:0]   CNT_LAST   = (MEM_ADDR_WIDTH + 1)'(MEM_SIZE - 1);
  localparam logic [MEM_ADDR_WIDTH:0]   CNT_ONE    = (MEM_ADDR_WIDTH + 1)'(1);

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_ADDR_WIDTH:0]   x_count_q, x_count_d;
  logic                      wrap_pulse_q, wrap_pulse_d;

  logic s_ready;
  logic wr_en;

  // Combinational handshake: ready depends on state and consumer flags only
  always_comb begin
    s_ready = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        wr_en   = bus.s_valid;
      end
      STREAM: begin
        s_ready = bus.next_write;
        wr_en   = bus.s_valid & bus.next_write & bus.ready_y;
      end
      default: begin
        s_ready = 1'b0;
        wr_en   = 1'b0;
      end
    endcase
    // clear suppresses any transfer in the cycle it is seen
    if (bus.clear) begin
      s_ready = 1'b0;
      wr_en   = 1'b0;
    end
  end

  // Next-state, pointer, count and wrap-pulse computation
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    x_count_d    = x_count_q;
    wrap_pulse_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (wr_en) begin
          if (x_count_q == CNT_LAST) begin
            // Last fill word: restart the pointer for later overwrites
            wr_ptr_d  = '0;
            x_count_d = CNT_FULL;
            state_d   = FULL;
          end else begin
            wr_ptr_d  = wr_ptr_q + ADDR_ONE;
            x_count_d = x_count_q + CNT_ONE;
          end
        end
      end
      FULL: begin
        if (bus.en_ext_ctrl) state_d = STREAM;
      end
      STREAM: begin
        if (wr_en) begin
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d     = '0;
            wrap_pulse_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_ONE;
          end
        end
        // Dropping out of streaming still lets this cycle's write complete
        if (!bus.en_ext_ctrl) state_d = FULL;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    if (bus.clear) begin
      state_d      = LOAD;
      wr_ptr_d     = '0;
      x_count_d    = '0;
      wrap_pulse_d = 1'b0;
    end
  end

  // State registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      x_count_q    <= '0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      x_count_q    <= x_count_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_ptr_q;
  assign bus.x_count     = x_count_q;
  assign bus.mem_full    = (state_q != LOAD);
  assign bus.wrap_pulse  = wrap_pulse_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_ctrl_vec_mem_write.sv
// Directed bench for ctrl_vec_mem_write: an 8-word instance covers fill,
// streaming, stalls, clear and reset; a 5-word instance covers wrap-around
// with a non-power-of-two size.
module tb_ctrl_vec_mem_write;

  localparam logic [31:0] ST_LOAD   = 32'd0;
  localparam logic [31:0] ST_FULL   = 32'd1;
  localparam logic [31:0] ST_STREAM = 32'd2;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ctrl_vec_mem_write_if #(.MEM_ADDR_WIDTH(3)) h8 ();
  ctrl_vec_mem_write_if #(.MEM_ADDR_WIDTH(3)) h5 ();

  ctrl_vec_mem_write #(.MEM_SIZE(8), .MEM_ADDR_WIDTH(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (h8.slave)
  );

  ctrl_vec_mem_write #(.MEM_SIZE(5), .MEM_ADDR_WIDTH(3)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (h5.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    h8.s_valid = 1'b0; h8.en_ext_ctrl = 1'b0; h8.next_write = 1'b0;
    h8.ready_y = 1'b0; h8.clear = 1'b0;
    h5.s_valid = 1'b0; h5.en_ext_ctrl = 1'b0; h5.next_write = 1'b0;
    h5.ready_y = 1'b0; h5.clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_state",   32'(h8.state_dbg),   ST_LOAD);
    chk("rst_addr",    32'(h8.mem_wr_addr), 32'd0);
    chk("rst_count",   32'(h8.x_count),     32'd0);
    chk("rst_full",    32'(h8.mem_full),    32'd0);
    chk("rst_wrap",    32'(h8.wrap_pulse),  32'd0);
    chk("rst_sready",  32'(h8.s_ready),     32'd1);
    chk("rst_wren0",   32'(h8.mem_wr_en),   32'd0);

    // Fill 8 words
    h8.s_valid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("fill_wren",  32'(h8.mem_wr_en),   32'd1);
      chk("fill_addr",  32'(h8.mem_wr_addr), 32'(i));
      chk("fill_count", 32'(h8.x_count),     32'(i));
      tick();
    end
    chk("full_count",  32'(h8.x_count),     32'd8);
    chk("full_flag",   32'(h8.mem_full),    32'd1);
    chk("full_sready", 32'(h8.s_ready),     32'd0);
    chk("full_wren",   32'(h8.mem_wr_en),   32'd0);
    chk("full_addr",   32'(h8.mem_wr_addr), 32'd0);
    chk("full_state",  32'(h8.state_dbg),   ST_FULL);

    // FULL without streaming enable: valid is ignored, nothing moves
    tick();
    chk("hold_state", 32'(h8.state_dbg),   ST_FULL);
    chk("hold_addr",  32'(h8.mem_wr_addr), 32'd0);
    chk("hold_count", 32'(h8.x_count),     32'd8);

    // Enter STREAM and write 9 beats
    h8.en_ext_ctrl = 1'b1; h8.next_write = 1'b1; h8.ready_y = 1'b1;
    #1;
    chk("enter_wren", 32'(h8.mem_wr_en), 32'd0);
    tick();
    chk("stream_state", 32'(h8.state_dbg), ST_STREAM);
    for (int i = 0; i < 9; i++) begin
      chk("strm_sready", 32'(h8.s_ready),     32'd1);
      chk("strm_wren",   32'(h8.mem_wr_en),   32'd1);
      chk("strm_addr",   32'(h8.mem_wr_addr), 32'(i % 8));
      chk("strm_wrap",   32'(h8.wrap_pulse),  (i == 8) ? 32'd1 : 32'd0);
      chk("strm_count",  32'(h8.x_count),     32'd8);
      tick();
    end
    chk("strm_wrap_end", 32'(h8.wrap_pulse),  32'd0);
    chk("strm_addr_end", 32'(h8.mem_wr_addr), 32'd1);

    // Consumer stall, then downstream stall
    h8.next_write = 1'b0;
    #1;
    chk("nw0_sready", 32'(h8.s_ready),   32'd0);
    chk("nw0_wren",   32'(h8.mem_wr_en), 32'd0);
    tick();
    chk("nw0_addr", 32'(h8.mem_wr_addr), 32'd1);
    h8.next_write = 1'b1; h8.ready_y = 1'b0;
    #1;
    chk("ry0_sready", 32'(h8.s_ready),   32'd1);
    chk("ry0_wren",   32'(h8.mem_wr_en), 32'd0);
    tick();
    chk("ry0_addr", 32'(h8.mem_wr_addr), 32'd1);

    // Leaving STREAM: the same-cycle write still lands
    h8.ready_y = 1'b1; h8.en_ext_ctrl = 1'b0;
    #1;
    chk("exit_wren", 32'(h8.mem_wr_en),   32'd1);
    chk("exit_addr", 32'(h8.mem_wr_addr), 32'd1);
    tick();
    chk("exit_state",  32'(h8.state_dbg),   ST_FULL);
    chk("exit_addr2",  32'(h8.mem_wr_addr), 32'd2);
    chk("exit_full",   32'(h8.mem_full),    32'd1);
    chk("exit_sready", 32'(h8.s_ready),     32'd0);

    // Back to STREAM, one write, then reset and clear together
    h8.en_ext_ctrl = 1'b1;
    tick();
    chk("re_state", 32'(h8.state_dbg),   ST_STREAM);
    chk("re_addr",  32'(h8.mem_wr_addr), 32'd2);
    tick();
    chk("re_addr2", 32'(h8.mem_wr_addr), 32'd3);
    reset = 1'b1; h8.clear = 1'b1;
    #1;
    chk("rc_wren",   32'(h8.mem_wr_en), 32'd0);
    chk("rc_sready", 32'(h8.s_ready),   32'd0);
    tick();
    reset = 1'b0; h8.clear = 1'b0; h8.en_ext_ctrl = 1'b0;
    #1;
    chk("rc_state",  32'(h8.state_dbg),   ST_LOAD);
    chk("rc_addr",   32'(h8.mem_wr_addr), 32'd0);
    chk("rc_count",  32'(h8.x_count),     32'd0);
    chk("rc_full",   32'(h8.mem_full),    32'd0);
    chk("rc_wrap",   32'(h8.wrap_pulse),  32'd0);
    chk("rc_sready", 32'(h8.s_ready),     32'd1);
    chk("rc_wren",   32'(h8.mem_wr_en),   32'd1);
    tick();
    chk("rc_next_addr",  32'(h8.mem_wr_addr), 32'd1);
    chk("rc_next_count", 32'(h8.x_count),     32'd1);

    // Reset mid-LOAD: strobe visible but progress discarded
    reset = 1'b1;
    #1;
    chk("rl_wren", 32'(h8.mem_wr_en), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rl_addr",  32'(h8.mem_wr_addr), 32'd0);
    chk("rl_count", 32'(h8.x_count),     32'd0);

    // Load 3 words, then clear with valid held high
    tick();
    tick();
    tick();
    chk("pre_clr_count", 32'(h8.x_count),     32'd3);
    chk("pre_clr_addr",  32'(h8.mem_wr_addr), 32'd3);
    h8.clear = 1'b1;
    #1;
    chk("clr_sready", 32'(h8.s_ready),   32'd0);
    chk("clr_wren",   32'(h8.mem_wr_en), 32'd0);
    tick();
    h8.clear = 1'b0; h8.s_valid = 1'b0;
    #1;
    chk("clr_state",  32'(h8.state_dbg),   ST_LOAD);
    chk("clr_addr",   32'(h8.mem_wr_addr), 32'd0);
    chk("clr_count",  32'(h8.x_count),     32'd0);
    chk("clr_sready", 32'(h8.s_ready),     32'd1);

    // Non-power-of-two size: 5-word fill then 6 stream writes
    reset = 1'b1;
    tick();
    reset = 1'b0;
    h5.s_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("m5_fill_addr",  32'(h5.mem_wr_addr), 32'(i));
      chk("m5_fill_wren",  32'(h5.mem_wr_en),   32'd1);
      chk("m5_fill_count", 32'(h5.x_count),     32'(i));
      tick();
    end
    chk("m5_full_count", 32'(h5.x_count),     32'd5);
    chk("m5_full_flag",  32'(h5.mem_full),    32'd1);
    chk("m5_full_addr",  32'(h5.mem_wr_addr), 32'd0);
    h5.en_ext_ctrl = 1'b1; h5.next_write = 1'b1; h5.ready_y = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("m5_strm_addr", 32'(h5.mem_wr_addr), 32'(i % 5));
      chk("m5_strm_wren", 32'(h5.mem_wr_en),   32'd1);
      chk("m5_strm_wrap", 32'(h5.wrap_pulse),  (i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("m5_end_addr", 32'(h5.mem_wr_addr), 32'd1);
    chk("m5_end_wrap", 32'(h5.wrap_pulse),  32'd0);
    chk("m5_end_count", 32'(h5.x_count),    32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
